// File: rtl/bit_serializer_if.sv
// Parallel-word / serial-line bundle between a serializer and its bit-select mux.
// The serializer drives ch/sel/tx/busy/done and consumes data/start/mux_out.
`timescale 1ns/1ps

interface bit_serializer_if #(
    parameter int n = 3
) ();
    logic [2**n-1:0] data;
    logic            start;
    logic [2**n-1:0] ch;
    logic [n-1:0]    sel;
    logic            mux_out;
    logic            tx;
    logic            busy;
    logic            done;

    // Handshake: a word is taken on the rising edge where start=1 and busy=0.
    // While busy=1, start and data are ignored. done pulses for one cycle when
    // the stop bit completes, and busy is already low in that cycle.
    modport master (
        output data, start, mux_out,
        input  ch, sel, tx, busy, done
    );

    modport slave (
        input  data, start, mux_out,
        output ch, sel, tx, busy, done
    );
endinterface

// File: rtl/bit_serializer.sv
// UART-style framer: start bit, 2**n data bits (LSB first) from an external mux, stop bit.
// Each bit lasts BAUD_DIV cycles; tx is the registered line value, one cycle behind state.
`timescale 1ns/1ps

module bit_serializer #(
    parameter int n        = 3,
    parameter int BAUD_DIV = 104
) (
    input  logic             clk,
    input  logic             rst,
    bit_serializer_if.slave  bus,
    output logic [1:0]       dbg_state
);
    localparam int W  = 2**n;
    localparam int CW = $clog2(BAUD_DIV);
    localparam logic [CW-1:0] CNT_MAX = CW'(BAUD_DIV - 1);
    localparam logic [n-1:0]  SEL_MAX = n'(W - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [n-1:0]    sel_q, sel_d;
    logic [W-1:0]    ch_q, ch_d;
    logic            tx_q, tx_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            tick;
    logic            line;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            sel_q   <= '0;
            ch_q    <= '0;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sel_q   <= sel_d;
            ch_q    <= ch_d;
            tx_q    <= tx_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sel_d   = sel_q;
        ch_d    = ch_q;
        done_d  = 1'b0;
        line    = 1'b1;
        tick    = (cnt_q == CNT_MAX);

        case (state_q)
            S_IDLE: begin
                line = 1'b1;
                if (bus.start) begin
                    ch_d    = bus.data;
                    sel_d   = '0;
                    cnt_d   = '0;
                    state_d = S_START;
                end
            end
            S_START: begin
                line = 1'b0;
                if (tick) state_d = S_DATA;
            end
            S_DATA: begin
                // The mux returns ch[sel] combinationally; tx_q registers it.
                line = bus.mux_out;
                if (tick) begin
                    if (sel_q == SEL_MAX) begin
                        state_d = S_STOP;
                        sel_d   = '0;
                    end else begin
                        sel_d = sel_q + n'(1);
                    end
                end
            end
            S_STOP: begin
                line = 1'b1;
                if (tick) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (state_q != S_IDLE) begin
            cnt_d = tick ? '0 : cnt_q + CW'(1);
        end

        tx_d   = line;
        busy_d = (state_d != S_IDLE);
    end

    assign bus.ch    = ch_q;
    assign bus.sel   = sel_q;
    assign bus.tx    = tx_q;
    assign bus.busy  = busy_q;
    assign bus.done  = done_q;
    assign dbg_state = state_q;
endmodule

// File: tb/tb_bit_serializer.sv
// Directed bench: two serializer instances (n=3/BAUD_DIV=4 and n=2/BAUD_DIV=2), each with a mux model.
// Expected line values are derived from frame position, not from DUT state.
`timescale 1ns/1ps

module tb_bit_serializer;
    localparam int BD = 4;

    logic clk = 1'b0;
    logic rst;
    logic [1:0] dbg_m, dbg_s;

    always #5 clk = ~clk;

    bit_serializer_if #(.n(3)) if_m ();
    bit_serializer_if #(.n(2)) if_s ();

    assign if_m.mux_out = if_m.ch[if_m.sel];
    assign if_s.mux_out = if_s.ch[if_s.sel];

    bit_serializer #(.n(3), .BAUD_DIV(4)) u_main (
        .clk(clk), .rst(rst), .bus(if_m), .dbg_state(dbg_m)
    );

    bit_serializer #(.n(2), .BAUD_DIV(2)) u_small (
        .clk(clk), .rst(rst), .bus(if_s), .dbg_state(dbg_s)
    );

    int vectors     = 0;
    int miscompares = 0;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Line value k cycles after acceptance: idle, start, nb data bits LSB first, stop.
    function automatic logic exp_tx(input int k, input logic [7:0] d, input int nb, input int bd);
        int b;
        if (k == 0) return 1'b1;
        b = (k - 1) / bd;
        if (b == 0) return 1'b0;
        if (b <= nb) return d[b-1];
        return 1'b1;
    endfunction

    function automatic int exp_sel(input int k, input int nb, input int bd);
        if (k >= bd && k < bd * (nb + 1)) return (k - bd) / bd;
        return 0;
    endfunction

    // Called at k=0 (just after the accepting edge); returns in the done cycle.
    task automatic frame_main(input string tag, input logic [7:0] d, input bit noise, input int inj_k);
        for (int k = 0; k <= 10 * BD; k++) begin
            check({tag, "_tx"},   32'(if_m.tx),   32'(exp_tx(k, d, 8, BD)));
            check({tag, "_busy"}, 32'(if_m.busy), 32'(k < 10 * BD));
            check({tag, "_done"}, 32'(if_m.done), 32'(k == 10 * BD));
            check({tag, "_sel"},  32'(if_m.sel),  32'(exp_sel(k, 8, BD)));
            check({tag, "_ch"},   32'(if_m.ch),   32'(d));
            if (inj_k >= 0 && k == inj_k) begin
                if_m.start = 1'b1;
                if_m.data  = 8'hFF;
            end else if (inj_k >= 0 && k == inj_k + 1) begin
                if_m.start = 1'b0;
            end
            if (noise) if_m.data = 8'($urandom_range(0, 255));
            if (k < 10 * BD) step();
        end
    endtask

    initial begin
        rst = 1'b1;
        if_m.start = 1'b0;
        if_m.data  = 8'h00;
        if_s.start = 1'b0;
        if_s.data  = 4'h0;
        step();
        step();
        check("rst_tx",   32'(if_m.tx),   32'd1);
        check("rst_busy", 32'(if_m.busy), 32'd0);
        check("rst_done", 32'(if_m.done), 32'd0);
        check("rst_sel",  32'(if_m.sel),  32'd0);
        check("rst_ch",   32'(if_m.ch),   32'd0);
        check("rst_s_tx", 32'(if_s.tx),   32'd1);
        rst = 1'b0;

        for (int i = 0; i < 50; i++) begin
            if_m.data = 8'($urandom_range(0, 255));
            step();
            check("idle_tx",   32'(if_m.tx),   32'd1);
            check("idle_busy", 32'(if_m.busy), 32'd0);
            check("idle_done", 32'(if_m.done), 32'd0);
            check("idle_sel",  32'(if_m.sel),  32'd0);
            check("idle_ch",   32'(if_m.ch),   32'd0);
        end

        // Single frame with data churning while busy
        if_m.data  = 8'hA5;
        if_m.start = 1'b1;
        step();
        if_m.start = 1'b0;
        frame_main("a5", 8'hA5, 1'b1, -1);
        step();
        step();

        // start + 0xFF at cycle 10 must be ignored
        if_m.data  = 8'h3C;
        if_m.start = 1'b1;
        step();
        if_m.start = 1'b0;
        frame_main("busy3c", 8'h3C, 1'b0, 10);
        step();
        step();

        // start held high: second word accepted on the edge after the done cycle
        if_m.data  = 8'h01;
        if_m.start = 1'b1;
        step();
        if_m.data  = 8'h80;
        frame_main("b2b1", 8'h01, 1'b0, -1);
        step();
        frame_main("b2b2", 8'h80, 1'b0, -1);
        if_m.start = 1'b0;
        step();
        step();

        // Reset 17 cycles into a 0x00 frame
        if_m.data  = 8'h00;
        if_m.start = 1'b1;
        step();
        if_m.start = 1'b0;
        for (int k = 1; k <= 17; k++) step();
        check("mid_pre_tx",   32'(if_m.tx),   32'd0);
        check("mid_pre_sel",  32'(if_m.sel),  32'd3);
        check("mid_pre_busy", 32'(if_m.busy), 32'd1);
        rst = 1'b1;
        #1;
        check("mid_async_tx",   32'(if_m.tx),   32'd1);
        check("mid_async_busy", 32'(if_m.busy), 32'd0);
        check("mid_async_sel",  32'(if_m.sel),  32'd0);
        check("mid_async_done", 32'(if_m.done), 32'd0);
        step();
        step();
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            check("post_rst_done", 32'(if_m.done), 32'd0);
            check("post_rst_busy", 32'(if_m.busy), 32'd0);
            check("post_rst_tx",   32'(if_m.tx),   32'd1);
        end
        if_m.data  = 8'h55;
        if_m.start = 1'b1;
        step();
        if_m.start = 1'b0;
        frame_main("r55", 8'h55, 1'b1, -1);
        step();

        // Small configuration: n=2, BAUD_DIV=2, data=0x6
        if_s.data  = 4'h6;
        if_s.start = 1'b1;
        step();
        if_s.start = 1'b0;
        for (int k = 0; k <= 12; k++) begin
            check("s6_tx",   32'(if_s.tx),   32'(exp_tx(k, 8'h06, 4, 2)));
            check("s6_busy", 32'(if_s.busy), 32'(k < 12));
            check("s6_done", 32'(if_s.done), 32'(k == 12));
            check("s6_sel",  32'(if_s.sel),  32'(exp_sel(k, 4, 2)));
            check("s6_ch",   32'(if_s.ch),   32'h6);
            if (k < 12) step();
        end
        step();
        check("s6_after_done", 32'(if_s.done), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/bit_serializer.md
BIT_SERIALIZER -- requirements
Module: bit_serializer

Interface
REQ-001 Parameter n, default 3, meaning sel width in bits; word width is 2**n bits.
REQ-002 Parameter BAUD_DIV, default 104, meaning clock cycles per serial bit; legal range >= 2.
REQ-003 clk  input  1  the single clock of the block; all state updates on its rising edge.
REQ-004 rst  input  1  reset; asynchronous and active-high.
REQ-005 data  input  2**n  parallel word to transmit; sampled only on an accepted start.
REQ-006 start  input  1  request to send data; accepted only when busy=0.
REQ-007 ch  output  2**n  registered copy of the accepted word; drives the channel inputs of the downstream mux.
REQ-008 sel  output  n  registered bit index; drives the select input of the downstream mux.
REQ-009 mux_out  input  1  selected bit returned by the mux (ch[sel]), combinational.
REQ-010 tx  output  1  registered serial line, idle high.
REQ-011 busy  output  1  high from the cycle after acceptance until the frame ends.
REQ-012 done  output  1  one-cycle pulse at end of frame.

Function
REQ-013 The block shall implement states IDLE, START, DATA and STOP, with busy=1 in every state except IDLE.
REQ-014 Acceptance occurs on a rising edge where state=IDLE and start=1: ch<=data, sel<=0, baud counter<=0, state<=START.
REQ-015 start while busy=1 shall be ignored, and changes on data while busy=1 shall not affect ch.
REQ-016 The baud counter shall count 0..BAUD_DIV-1 in START, DATA and STOP; the cycle at BAUD_DIV-1 is the bit tick; the counter wraps to 0 on the tick.
REQ-017 START tick: state<=DATA, sel stays 0.
REQ-018 DATA tick with sel<2**n-1: sel<=sel+1.
REQ-019 DATA tick with sel=2**n-1: state<=STOP, sel<=0.
REQ-020 STOP tick: state<=IDLE, done<=1 for exactly that next cycle.
REQ-021 Line value per state: IDLE=1, START=0, DATA=mux_out, STOP=1; tx shall be this value registered, lagging state by exactly one cycle.
REQ-022 Bits are sent LSB first (ch[0] first); every bit, including start and stop, lasts exactly BAUD_DIV cycles on tx.
REQ-023 Frame length shall be (2**n+2)*BAUD_DIV cycles from acceptance to the done pulse.
REQ-024 In the done cycle state=IDLE and busy=0, so start=1 in that cycle shall be accepted (back-to-back frames, no gap beyond one tx-lag cycle).
REQ-025 The counter and sel shall never exceed BAUD_DIV-1 and 2**n-1 respectively; no other wrap is permitted.

Reset
REQ-026 While rst=1 the block shall force, asynchronously: state=IDLE, tx=1, busy=0, done=0, sel=0, ch=0, and baud counter=0.
REQ-027 Reset mid-frame shall abort the frame with no done pulse; after rst falls, the first start shall begin a complete new frame.

Verification (n=3, BAUD_DIV=4 unless stated)
REQ-028 Idle after reset: rst pulse, no start -> tx=1, busy=0, done=0, sel=0 and ch=0 for 50 cycles.
REQ-029 Single frame: data=0xA5 with start for 1 cycle -> tx holds, 4 cycles each, 0 | 1,0,1,0,0,1,0,1 | 1; sel steps 0..7; done pulses once 40 cycles after acceptance.
REQ-030 Start while busy: start re-asserted with data=0xFF at cycle 10 of a 0x3C frame -> the frame is 0x3C unchanged and ch stays 0x3C.
REQ-031 Back-to-back: start held high with data 0x01 then 0x80 -> two frames with the second accepted in the done cycle; tx never idles longer than 1 cycle between the stop and start bits.
REQ-032 Reset mid-frame: rst asserted at cycle 17 of a 0x00 frame -> tx=1 in the same cycle (async), busy=0, no done; a following 0x55 frame is correct.
REQ-033 Small configuration: n=2, BAUD_DIV=2, data=0x6 -> tx is 0,0,1,1,0,1 with 2 cycles each; done 12 cycles after acceptance.
